// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sub_pkg
// Brief   : Shared types and sizing helpers for the chunked subtractor.
// Revision: 1.0 - initial release
// ============================================================================
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int calc_idx_w(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_chunk.sv
`default_nettype none
// ============================================================================
// Module  : sub_chunk
// Brief   : Combinational CHUNK-bit lookahead slice computing a + ~b + cin.
// Revision: 1.0 - initial release
// ============================================================================
module sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_diff,
    output logic             o_cout
);

    logic [CHUNK-1:0] w_b_n;
    logic [CHUNK-1:0] w_g;
    logic [CHUNK-1:0] w_p;
    logic [CHUNK:0]   w_c;

    assign w_b_n  = ~i_b;
    assign w_g    = i_a & w_b_n;
    assign w_p    = i_a ^ w_b_n;
    assign w_c[0] = i_cin;

    // Each carry comes from the group generate/propagate of bits [0..gi].
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cla
        logic w_gg;
        logic w_pp;
        always_comb begin
            w_gg = w_g[0];
            w_pp = w_p[0];
            for (int k = 1; k <= gi; k++) begin
                w_gg = w_g[k] | (w_p[k] & w_gg);
                w_pp = w_pp & w_p[k];
            end
        end
        assign w_c[gi+1] = w_gg | (w_pp & i_cin);
    end

    assign o_diff = w_p ^ w_c[CHUNK-1:0];
    assign o_cout = w_c[CHUNK];

endmodule
`default_nettype wire

// File: rtl/chunked_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : chunked_subtractor
// Brief   : Multi-cycle unsigned subtractor, one CHUNK-bit slice per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module chunked_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
);

    localparam int                NCHUNK     = calc_nchunk(WIDTH, CHUNK);
    localparam int                IDX_W      = calc_idx_w(WIDTH, CHUNK);
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0]  C_MASK     = WIDTH'({CHUNK{1'b1}});

    state_t           r_state;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_sub;
    logic [WIDTH-1:0] r_diff;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH:0]   r_result;
    logic             r_ready;
    logic             r_valid;

    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_min_slice;
    logic [CHUNK-1:0] w_sub_slice;
    logic [CHUNK-1:0] w_slice_diff;
    logic             w_cout;
    logic [WIDTH-1:0] w_diff_next;

    assign w_base      = 32'(r_idx) * 32'(CHUNK);
    assign w_min_slice = CHUNK'(r_min >> w_base);
    assign w_sub_slice = CHUNK'(r_sub >> w_base);
    assign w_diff_next = (r_diff & ~(C_MASK << w_base)) | (WIDTH'(w_slice_diff) << w_base);

    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .i_a    (w_min_slice),
        .i_b    (w_sub_slice),
        .i_cin  (r_carry),
        .o_diff (w_slice_diff),
        .o_cout (w_cout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_min    <= '0;
            r_sub    <= '0;
            r_diff   <= '0;
            r_carry  <= 1'b1;
            r_idx    <= '0;
            r_result <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_min   <= i_min;
                        r_sub   <= i_sub;
                        r_idx   <= '0;
                        r_carry <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_diff  <= w_diff_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == C_LAST_IDX) begin
                        // Final carry-out is the inverted borrow.
                        r_result <= {~w_cout, w_diff_next};
                        r_valid  <= 1'b1;
                        r_idx    <= '0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_valid  = r_valid;
    assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_chunked_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : tb_chunked_subtractor
// Brief   : Scoreboard bench for chunked_subtractor over several WIDTH/CHUNK sets.
// Revision: 1.0 - initial release
// ============================================================================
module tb_chunked_subtractor;

    localparam int NOPS     = 1000;
    localparam int MAIN_RND = 300;

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int cfg_w(input int i);
        return (i == 3) ? 16 : 8;
    endfunction

    function automatic int cfg_c(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 8;
            default: return 4;
        endcase
    endfunction

    logic rst_init  = 1'b1;
    logic rst_pulse = 1'b0;

    // ---------------- main instance, WIDTH=8 CHUNK=4 ----------------
    logic       m_i_valid = 1'b0, m_i_ready = 1'b0, m_ready, m_valid;
    logic [7:0] m_min = '0, m_sub = '0;
    logic [8:0] m_result;

    chunked_subtractor #(.WIDTH(8), .CHUNK(4)) u_dut (
        .i_clk    (clk),
        .i_rst    (rst_init | rst_pulse),
        .i_valid  (m_i_valid),
        .o_ready  (m_ready),
        .i_min    (m_min),
        .i_sub    (m_sub),
        .o_valid  (m_valid),
        .i_ready  (m_i_ready),
        .o_result (m_result)
    );

    logic [8:0] m_exp_q[$];
    longint     m_k_q[$];
    longint     m_cons_q[$];
    int         m_sent = 0, m_done_cnt = 0, m_hold = 0, m_rdy_mode = 0;

    initial begin : p_mmon
        bit         have;
        logic [8:0] held;
        int         hold_cnt;
        have = 0; held = '0; hold_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_init || rst_pulse) begin
                have = 0;
                m_i_ready = 1'b0;
            end else if (m_valid) begin
                if (!have) begin
                    if (m_exp_q.size() == 0) chk("m_unexpected_valid", 1, 0);
                    else begin
                        chk("m_result", m_result, m_exp_q.pop_front());
                        chk("m_latency", cyc - m_k_q.pop_front(), 2);
                    end
                    have = 1; held = m_result; hold_cnt = m_hold; m_hold = 0;
                end else chk("m_result_stable", m_result, held);
                if (hold_cnt > 0) begin
                    chk("m_ready_low_in_done", m_ready, 0);
                    hold_cnt--;
                    m_i_ready = 1'b0;
                end else begin
                    m_i_ready = m_rdy_mode != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (m_i_ready) begin
                        have = 0;
                        m_cons_q.push_back(cyc + 1);
                        m_done_cnt++;
                    end
                end
            end else begin
                if (have) chk("m_valid_held", m_valid, 1);
                have = 0;
                m_i_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp,
                        output longint k);
        int t;
        m_i_valid = 1'b1; m_min = a; m_sub = b;
        t = 0;
        while (!m_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!m_ready) chk("m_accept_timeout", 0, 1);
        k = cyc + 1;
        m_exp_q.push_back(exp);
        m_k_q.push_back(k);
        m_sent++;
        @(negedge clk);
        m_i_valid = 1'b0; m_min = 8'($urandom); m_sub = 8'($urandom);
    endtask

    task automatic churn(input int n);
        repeat (n) begin
            @(negedge clk);
            m_min = 8'($urandom); m_sub = 8'($urandom);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (m_done_cnt != m_sent && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (m_done_cnt != m_sent) chk("m_drain_timeout", m_done_cnt, m_sent);
    endtask

    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b);
        int d;
        d = int'(a) - int'(b);
        return {d < 0, 8'((d + 256) % 256)};
    endfunction

    // ---------------- extra configurations ----------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
        localparam int W = cfg_w(gi);
        localparam int C = cfg_c(gi);
        localparam int N = W / C;

        logic         vi = 1'b0, ri = 1'b0, vo, ro;
        logic [W-1:0] a = '0, b = '0;
        logic [W:0]   res;
        logic [W:0]   eq[$];
        longint       kq[$];
        int           ndone = 0;

        chunked_subtractor #(.WIDTH(W), .CHUNK(C)) u_dut (
            .i_clk    (clk),
            .i_rst    (rst_init),
            .i_valid  (vi),
            .o_ready  (ro),
            .i_min    (a),
            .i_sub    (b),
            .o_valid  (vo),
            .i_ready  (ri),
            .o_result (res)
        );

        initial begin : p_drv
            int   t;
            longint lim;
            @(negedge clk);
            while (rst_init) @(negedge clk);
            for (int n = 0; n < NOPS; n++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    a = W'($urandom); b = W'($urandom);
                end
                a = W'($urandom); b = W'($urandom);
                case ($urandom_range(0, 7))
                    0: b = a;
                    1: a = '0;
                    2: b = '1;
                    default: ;
                endcase
                vi = 1'b1;
                t = 0;
                while (!ro && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                if (!ro) chk("cfg_accept_timeout", gi, 99);
                lim = 1;
                eq.push_back({a < b, W'(a - b)});
                kq.push_back(cyc + 1);
                @(negedge clk);
                vi = 1'b0; a = W'($urandom); b = W'($urandom);
            end
        end

        initial begin : p_mon
            bit         have;
            logic [W:0] held;
            have = 0; held = '0;
            forever begin
                @(negedge clk);
                if (rst_init) begin
                    have = 0;
                    ri = 1'b0;
                end else if (vo) begin
                    if (!have) begin
                        if (eq.size() == 0) chk("cfg_unexpected_valid", gi, 99);
                        else begin
                            chk("cfg_result", res, eq.pop_front());
                            chk("cfg_latency", cyc - kq.pop_front(), N);
                        end
                        have = 1; held = res;
                    end else chk("cfg_result_stable", res, held);
                    ri = 1'($urandom_range(0, 1));
                    if (ri) begin
                        have = 0;
                        ndone++;
                    end
                end else begin
                    if (have) chk("cfg_valid_held", vo, 1);
                    have = 0;
                    ri = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : p_main
        longint k, kb;
        int     n0, t;
        logic [7:0] ra, rb;

        repeat (3) @(negedge clk);
        chk("reset_ready", m_ready, 1);
        chk("reset_valid", m_valid, 0);
        chk("reset_result", m_result, 0);
        rst_init = 1'b0;

        // Directed vectors; operands churn during RUN via the idle-time randomisation.
        send(8'h35, 8'h12, 9'h023, k); churn(4);
        send(8'h10, 8'h01, 9'h00F, k); churn(1);
        send(8'h00, 8'h01, 9'h1FF, k);
        send(8'hF0, 8'h0F, 9'h0E1, k); churn(3);
        send(8'hAA, 8'hAA, 9'h000, k);
        drain();

        // Back-pressure: next operands held valid while the result waits.
        churn(1);
        n0 = m_done_cnt;
        m_hold = 5;
        send(8'h5A, 8'h3C, 9'h01E, k);
        send(8'h01, 8'h02, 9'h1FF, kb);
        drain();
        if (m_cons_q.size() > n0) chk("m_bp_accept_edge", kb, m_cons_q[n0] + 1);
        else chk("m_bp_consume_missing", m_cons_q.size(), n0 + 1);

        // Reset in the middle of RUN discards the operation.
        churn(1);
        send(8'h00, 8'h01, 9'h1FF, k);
        rst_pulse = 1'b1;
        @(negedge clk);
        rst_pulse = 1'b0;
        chk("rst_mid_valid", m_valid, 0);
        chk("rst_mid_ready", m_ready, 1);
        chk("rst_mid_result", m_result, 0);
        m_exp_q.delete();
        m_k_q.delete();
        m_sent--;
        send(8'h35, 8'h12, 9'h023, k);
        drain();

        // Randomised traffic with random back-pressure.
        m_rdy_mode = 1;
        for (int n = 0; n < MAIN_RND; n++) begin
            churn($urandom_range(0, 2));
            ra = 8'($urandom); rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            send(ra, rb, model8(ra, rb), k);
        end
        drain();

        t = 0;
        while (t < 60000 && (g_cfg[0].ndone < NOPS || g_cfg[1].ndone < NOPS ||
                             g_cfg[2].ndone < NOPS || g_cfg[3].ndone < NOPS)) begin
            @(negedge clk);
            t++;
        end
        chk("cfg0_done", g_cfg[0].ndone, NOPS);
        chk("cfg1_done", g_cfg[1].ndone, NOPS);
        chk("cfg2_done", g_cfg[2].ndone, NOPS);
        chk("cfg3_done", g_cfg[3].ndone, NOPS);
        chk("m_queue_empty", m_exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chunked_subtractor.md
# chunked_subtractor

Multi-cycle unsigned subtractor: computes `i_min - i_sub` over `WIDTH/CHUNK` clock cycles, one `CHUNK`-bit slice per cycle, with a registered borrow between slices. It pairs with the combinational lookahead adder in the arithmetic datapath: it handles subtraction and borrow detection where a full-width single-cycle chain would miss timing. Operands enter through a valid/ready handshake, and the result leaves through one.

## Interface
- `WIDTH`, default 8: operand width. Must be a multiple of `CHUNK`.
- `CHUNK`, default 4: bits processed per cycle. `1 <= CHUNK <= WIDTH`.
- `i_clk`, input, 1: clock. All logic is on the rising edge.
- `i_rst`, input, 1: reset. Synchronous, active-high.
- `i_valid`, input, 1: operands valid.
- `o_ready`, output, 1: block can accept operands.
- `i_min`, input, `WIDTH`: minuend, unsigned.
- `i_sub`, input, `WIDTH`: subtrahend, unsigned.
- `o_valid`, output, 1: result valid.
- `i_ready`, input, 1: downstream accepts result.
- `o_result`, output, `WIDTH+1`: `{borrow, difference}`. The difference is modulo 2^WIDTH. The borrow is 1 iff `i_min < i_sub`.

## Operation
- `NCHUNK = WIDTH/CHUNK`.
- FSM states: `IDLE`, `RUN`, `DONE`.
- `IDLE`:
  - `o_ready=1`, `o_valid=0`.
  - On `i_valid & o_ready`: latch both operands, clear the chunk index, set the internal carry to 1, go to `RUN`.
- `RUN`:
  - `o_ready=0`.
  - Each cycle computes slice `idx`: `min_slice + ~sub_slice + carry`.
  - The low `CHUNK` bits are written to `diff[idx*CHUNK +: CHUNK]`; the carry-out is registered as the next carry.
  - `idx` increments. After slice `NCHUNK-1`, go to `DONE`.
- `DONE`:
  - `o_valid=1`, `o_result = {~carry, diff}`, where the final carry is the inverted borrow.
  - On `i_ready`, go to `IDLE`.
  - `o_result` is held stable while `o_valid & ~i_ready`.
- Only one operation is in flight. Inputs are not sampled outside the `IDLE` accept cycle; operand changes during `RUN`/`DONE` are ignored.
- Operands arriving while `o_ready=0` are not lost: the upstream holds `i_valid` and they are accepted on a later `IDLE` cycle.
- Reset, from any state including mid-`RUN` or `DONE` awaiting `i_ready`:
  - Next cycle: state `IDLE`, `o_valid=0`, `o_ready=1`, `o_result=0`, `idx=0`, carry=1.
  - Any partial result is discarded.
  - Reset has priority over every handshake in the same cycle.
- `o_result` is 0 from reset until the first completion. Between operations it holds the last result, valid only with `o_valid`.

## Timing
- Accept at edge k, when `i_valid & o_ready` is sampled.
- Slices are processed at edges k+1 through k+NCHUNK.
- `o_valid` is high starting the cycle after edge k+NCHUNK, so latency is `NCHUNK` cycles from acceptance.
- With `CHUNK=WIDTH`: one `RUN` cycle, latency 1.
- Result consumed at edge m (`o_valid & i_ready`): `o_ready=1` after edge m. The earliest next accept is edge m+1.
- Maximum throughput: one result per `NCHUNK+2` cycles.
- `o_ready` and `o_valid` are decoded from the registered state only. There is no combinational path from `i_valid` or `i_ready` to any output.
- Critical path: one `CHUNK`-bit lookahead subtract plus carry register.

## Structure
- Package `sub_pkg`:
  - `state_t` enum (`IDLE`, `RUN`, `DONE`).
  - Helper function computing `NCHUNK` and the index width `$clog2(NCHUNK)`, minimum 1.
- Sub-module `sub_chunk` (parameter `CHUNK`):
  - Combinational lookahead slice with inputs a, b, carry-in and outputs diff, carry-out.
  - Internally inverts b and reuses the generate/propagate lookahead structure.
- Top level holds the FSM, operand registers, the diff register, the carry register and the index counter.

## Test plan
- `WIDTH=8`, `CHUNK=4`, `0x35 - 0x12`: `o_result=9'h023`, `o_valid` exactly 2 cycles after accept.
- `0x10 - 0x01` (borrow crosses the slice boundary): `9'h00F`. `0x00 - 0x01`: `9'h1FF`. `0xF0 - 0x0F`: `9'h0E1`. `0xAA - 0xAA`: `9'h000`.
- Back-pressure: hold `i_ready=0` for 5 cycles after `o_valid`. `o_result` and `o_valid` must stay stable, and `o_ready` must stay 0 while `i_valid` is held high with new operands. The new operands are accepted the cycle after the result is consumed.
- Pulse `i_rst` during `RUN` of `0x00 - 0x01`: next cycle `o_valid=0`, `o_ready=1`, `o_result=0`. A following `0x35 - 0x12` returns `9'h023`.
- Change `i_min` and `i_sub` every cycle during `RUN`: the result reflects only the operands latched at accept.
- Randomized run of 1000 operations at `CHUNK=1, 2, 8` with `WIDTH=8`, plus `WIDTH=16`, `CHUNK=4`: compare `o_result` against `{i_min < i_sub, i_min - i_sub}`, and check latency equals `NCHUNK`.
